// File: rtl/mlp_layer2_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// mlp_pkg : shared sizes, data types and FSM states for layer 2 (rev 1.0)
// ----------------------------------------------------------------------
package mlp_pkg;

  localparam int N_IN   = 32;
  localparam int N_OUT  = 10;
  localparam int W_W    = 16;
  localparam int A_W    = 16;
  localparam int ACC_W  = 40;
  localparam int ADDR_W = 7;

  typedef logic signed [W_W-1:0]   wt_t;
  typedef logic signed [A_W-1:0]   act_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_ARGMAX = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mlp_layer2_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// mlp_layer2_seq_if : control, memory and result bus of layer 2 (rev 1.0)
// ----------------------------------------------------------------------
interface mlp_layer2_seq_if;
  import mlp_pkg::*;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [ADDR_W-1:0]        wt_addr;
  logic [ADDR_W-1:0]        act_addr;
  logic [N_OUT*W_W-1:0]     wt_data;
  logic [A_W-1:0]           act_data;
  logic [N_OUT*ACC_W-1:0]   logits;
  logic                     logits_valid;
  logic [3:0]               class_idx;
  logic                     class_valid;

  modport master (
    input  start, wt_data, act_data,
    output busy, done, wt_addr, act_addr, logits, logits_valid,
           class_idx, class_valid
  );

  modport slave (
    output start, wt_data, act_data,
    input  busy, done, wt_addr, act_addr, logits, logits_valid,
           class_idx, class_valid
  );

endinterface
`default_nettype wire

// File: rtl/mlp_layer2_seq_mac_lane.sv
`default_nettype none
// ----------------------------------------------------------------------
// mlp_mac_lane : one signed multiply-accumulate logit lane (rev 1.0)
// ----------------------------------------------------------------------
module mlp_mac_lane
  import mlp_pkg::*;
(
  input  wire logic clk,
  input  wire logic clr,
  input  wire logic en,
  input  act_t      act,
  input  wt_t       wt,
  output acc_t      acc
);

  logic signed [A_W+W_W-1:0] w_prod;

  assign w_prod = act * wt;

  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + acc_t'(w_prod);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mlp_layer2_seq.sv
`default_nettype none
// ----------------------------------------------------------------------
// mlp_layer2_seq : 32->10 output-layer MAC sequencer with argmax (rev 1.0)
// ----------------------------------------------------------------------
module mlp_layer2_seq
  import mlp_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst,
  mlp_layer2_seq_if.master  bus
);

  state_t             r_state;
  logic               r_rd_valid;
  logic [ADDR_W-1:0]  r_addr;
  logic [3:0]         r_cnt;
  logic [3:0]         r_best_idx;
  acc_t               r_best_val;

  acc_t                    w_acc [N_OUT];
  logic [N_OUT*ACC_W-1:0]  w_logits;
  acc_t                    w_cand;
  logic                    w_better;
  logic                    w_clr;

  // Accumulators clear on reset and on the very edge a start is accepted.
  assign w_clr    = rst || ((r_state == ST_IDLE) && bus.start);
  assign w_cand   = w_acc[r_cnt];
  assign w_better = (w_cand > r_best_val);

  assign bus.wt_addr  = r_addr;
  assign bus.act_addr = r_addr;
  assign bus.logits   = w_logits;

  generate
    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
      mlp_mac_lane u_lane (
        .clk (clk),
        .clr (w_clr),
        .en  (r_rd_valid),
        .act (bus.act_data),
        .wt  (bus.wt_data[j*W_W +: W_W]),
        .acc (w_acc[j])
      );
    end
  endgenerate

  always_comb begin
    w_logits = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_logits[j*ACC_W +: ACC_W] = w_acc[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_rd_valid       <= 1'b0;
      r_addr           <= '0;
      r_cnt            <= '0;
      r_best_idx       <= '0;
      r_best_val       <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.logits_valid <= 1'b0;
      bus.class_idx    <= '0;
      bus.class_valid  <= 1'b0;
    end else begin
      bus.done   <= 1'b0;
      // Read data lags the address by one cycle through the registered memories.
      r_rd_valid <= (r_state == ST_FETCH);
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state          <= ST_FETCH;
            r_addr           <= '0;
            bus.busy         <= 1'b1;
            bus.logits_valid <= 1'b0;
            bus.class_valid  <= 1'b0;
            bus.class_idx    <= '0;
          end
        end
        ST_FETCH: begin
          if (r_addr == ADDR_W'(N_IN - 1)) begin
            r_state <= ST_DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          r_state          <= ST_ARGMAX;
          r_addr           <= '0;
          r_cnt            <= '0;
          bus.logits_valid <= 1'b1;
        end
        ST_ARGMAX: begin
          if (r_cnt == 4'd0) begin
            r_best_val <= w_acc[0];
            r_best_idx <= 4'd0;
            r_cnt      <= 4'd1;
          end else begin
            // Strict compare keeps the lowest index on ties.
            if (w_better) begin
              r_best_val <= w_cand;
              r_best_idx <= r_cnt;
            end
            if (r_cnt == 4'(N_OUT - 1)) begin
              r_state         <= ST_DONE;
              bus.class_idx   <= w_better ? r_cnt : r_best_idx;
              bus.class_valid <= 1'b1;
              bus.done        <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer2_seq.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_mlp_layer2_seq : directed self-checking bench for mlp_layer2_seq (rev 1.0)
// ----------------------------------------------------------------------
module tb_mlp_layer2_seq;
  import mlp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mlp_layer2_seq_if bus ();

  mlp_layer2_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N_OUT*W_W-1:0] wt_mem  [N_IN];
  logic [A_W-1:0]       act_mem [N_IN];

  // Registered-read memory models, one cycle of latency.
  always @(posedge clk) begin
    bus.wt_data  <= wt_mem[bus.wt_addr[4:0]];
    bus.act_data <= act_mem[bus.act_addr[4:0]];
  end

  int n_assert = 0;
  int n_fail   = 0;

  logic [ACC_W-1:0] exp_l [N_OUT];
  logic [3:0]       exp_cls;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"},   64'(bus.busy), 64'd0);
    chk({pfx, "_done"},   64'(bus.done), 64'd0);
    chk({pfx, "_logits"}, 64'(|bus.logits), 64'd0);
    chk({pfx, "_lvalid"}, 64'(bus.logits_valid), 64'd0);
    chk({pfx, "_cvalid"}, 64'(bus.class_valid), 64'd0);
    chk({pfx, "_cls"},    64'(bus.class_idx), 64'd0);
    chk({pfx, "_waddr"},  64'(bus.wt_addr), 64'd0);
    chk({pfx, "_aaddr"},  64'(bus.act_addr), 64'd0);
  endtask

  task automatic check_results(input string pfx);
    for (int j = 0; j < N_OUT; j++) begin
      chk($sformatf("%s_logit%0d", pfx, j), 64'(bus.logits[j*ACC_W +: ACC_W]), 64'(exp_l[j]));
    end
    chk({pfx, "_cls"},    64'(bus.class_idx), 64'(exp_cls));
    chk({pfx, "_lvalid"}, 64'(bus.logits_valid), 64'd1);
    chk({pfx, "_cvalid"}, 64'(bus.class_valid), 64'd1);
  endtask

  // Entered and left at a falling edge; start is raised immediately.
  task automatic do_run(input string pfx, input int pulse_at, input bit pulse_done, input int rst_at);
    bit  seen;
    int  exp_a;
    int  n_done;
    seen = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      bus.start = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_zero({pfx, "_rst"});
        n_done = 0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (bus.done) n_done++;
        end
        chk({pfx, "_no_done"}, 64'(n_done), 64'd0);
        return;
      end
      exp_a = (i <= N_IN - 1) ? i : ((i == N_IN) ? N_IN - 1 : 0);
      chk($sformatf("%s_addr_eq%0d", pfx, i), 64'(bus.act_addr), 64'(bus.wt_addr));
      chk($sformatf("%s_addr%0d", pfx, i), 64'(bus.wt_addr), 64'(exp_a));
      if (i == 0)  chk({pfx, "_busy0"}, 64'(bus.busy), 64'd1);
      if (i == 32) chk({pfx, "_lvalid32"}, 64'(bus.logits_valid), 64'd0);
      if (i == 33) chk({pfx, "_lvalid33"}, 64'(bus.logits_valid), 64'd1);
      if (bus.done) begin
        seen = 1'b1;
        chk({pfx, "_done_cycle"}, 64'(i), 64'd43);
        chk({pfx, "_busy_done"}, 64'(bus.busy), 64'd1);
        if (pulse_done) bus.start = 1'b1;
        break;
      end
      if (i == pulse_at) bus.start = 1'b1;
      @(negedge clk);
    end
    chk({pfx, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    chk({pfx, "_busy_after"}, 64'(bus.busy), 64'd0);
    chk({pfx, "_done_after"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      wt_mem[k]  = '0;
      act_mem[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    // All-ones: ties everywhere, lowest index wins.
    for (int k = 0; k < N_IN; k++) begin
      act_mem[k] = 16'h0001;
      for (int j = 0; j < N_OUT; j++) wt_mem[k][j*W_W +: W_W] = 16'h0001;
    end
    for (int j = 0; j < N_OUT; j++) exp_l[j] = 40'd32;
    exp_cls = 4'd0;
    do_run("t1", -1, 1'b0, -1);
    check_results("t1");

    for (int k = 0; k < N_IN; k++) begin
      for (int j = 0; j < N_OUT; j++) wt_mem[k][j*W_W +: W_W] = 16'(j);
    end
    for (int j = 0; j < N_OUT; j++) exp_l[j] = 40'(32 * j);
    exp_cls = 4'd9;
    do_run("t2", -1, 1'b0, -1);
    check_results("t2");

    for (int k = 0; k < N_IN; k++) begin
      act_mem[k] = 16'hFFFF;
      for (int j = 0; j < N_OUT; j++) wt_mem[k][j*W_W +: W_W] = (j == 5) ? 16'h0001 : 16'h0002;
    end
    for (int j = 0; j < N_OUT; j++) exp_l[j] = (j == 5) ? 40'hFF_FFFF_FFE0 : 40'hFF_FFFF_FFC0;
    exp_cls = 4'd5;
    do_run("t3", -1, 1'b0, -1);
    check_results("t3");

    // Row-dependent data exposes any address/data misalignment.
    for (int k = 0; k < N_IN; k++) begin
      act_mem[k] = 16'(k + 1);
      for (int j = 0; j < N_OUT; j++) wt_mem[k][j*W_W +: W_W] = (j == 3) ? 16'(k) : 16'h0001;
    end
    for (int j = 0; j < N_OUT; j++) exp_l[j] = (j == 3) ? 40'd10912 : 40'd528;
    exp_cls = 4'd3;
    do_run("t4", -1, 1'b0, -1);
    check_results("t4");

    do_run("t5a", 10, 1'b1, -1);
    check_results("t5a");
    do_run("t5b", -1, 1'b0, -1);
    check_results("t5b");

    for (int k = 0; k < N_IN; k++) begin
      act_mem[k] = 16'hFFFF;
      for (int j = 0; j < N_OUT; j++) wt_mem[k][j*W_W +: W_W] = (j == 5) ? 16'h0001 : 16'h0002;
    end
    for (int j = 0; j < N_OUT; j++) exp_l[j] = (j == 5) ? 40'hFF_FFFF_FFE0 : 40'hFF_FFFF_FFC0;
    exp_cls = 4'd5;
    do_run("t6a", -1, 1'b0, 20);
    do_run("t6b", -1, 1'b0, -1);
    check_results("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
